des_array_controller: RTL and testbench

Parametrised multi-core successor to the single-core DES wrapper. It drives `NUM_CORES` `des_block` instances from one CPU command port, with a per-core region register and per-core run state. Finished results are collected through a round-robin arbiter into a valid/ready output register that reports the core ID and the full 64-bit key candidate. It sits between the CPU command interface and the DES search cores.

---
 rtl/des_block.sv | 55 +++++
 rtl/des_array_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_des_array_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_block.sv
// Stand-in DES key-search core: after start it walks its counter until the counter equals
// the target held in KEY[63-N:0], then raises done until restart_block.
module des_block #(
    parameter int unsigned  N   = 32,
    parameter logic [767:0] KEY = 768'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            restart_block,
    input  logic            test_enabled,
    input  logic            test_advance,
    input  logic [N-1:0]    region,
    output logic [63-N:0]   counter_out,
    output logic [63:0]     ciphertext_out,
    output logic            done
);
    localparam int unsigned     CW     = 64 - N;
    localparam logic [CW-1:0]   Target = KEY[CW-1:0];
    localparam logic [63:0]     Whiten = KEY[127:64];

    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;
    logic          w_step;

    assign w_step = r_run && (!test_enabled || test_advance);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (restart_block) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (w_step) begin
            if (r_cnt == Target) begin
                r_done <= 1'b1;
                r_run  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign counter_out    = r_cnt;
    assign ciphertext_out = {region, r_cnt} ^ Whiten;
    assign done           = r_done;
endmodule

// File: rtl/des_array_controller.sv
// Multi-core DES search controller: one CPU command port drives NUM_CORES des_block cores,
// and finished results are collected round-robin into a valid/ready output register.
module des_array_controller #(
    parameter int unsigned  NUM_CORES = 4,
    parameter int unsigned  N         = 32,
    parameter logic [767:0] KEY       = 768'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          cmd,
    input  logic                 cmd_valid,
    input  logic [31:0]          region,
    output logic                 cmd_read,
    output logic                 cmd_error,
    output logic                 busy,
    output logic [NUM_CORES-1:0] core_done_mask,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [3:0]           result_core,
    output logic [63:0]          counter,
    output logic [63:0]          ciphertext
);
    localparam int unsigned CW        = 64 - N;
    localparam logic [3:0]  OpLoad    = 4'd0;
    localparam logic [3:0]  OpStart   = 4'd1;
    localparam logic [3:0]  OpRestart = 4'd3;

    typedef enum logic [1:0] {CIdle, CExec, CAck} cmd_state_e;
    typedef enum logic [1:0] {CoreIdle, CoreRun, CoreDone, CoreReported} core_state_e;

    cmd_state_e           r_cmd_state;
    core_state_e          r_core_state [NUM_CORES];
    logic [N-1:0]         r_region [NUM_CORES];
    logic [NUM_CORES-1:0] r_start;
    logic [NUM_CORES-1:0] r_restart;
    logic                 r_cmd_read;
    logic                 r_cmd_error;
    logic                 r_result_valid;
    logic [3:0]           r_result_core;
    logic [63:0]          r_counter;
    logic [63:0]          r_ciphertext;
    logic [3:0]           r_last;

    logic [NUM_CORES-1:0] w_done;
    logic [CW-1:0]        w_core_cnt [NUM_CORES];
    logic [63:0]          w_core_ct [NUM_CORES];
    logic [3:0]           w_op;
    logic [3:0]           w_idx;
    logic                 w_bcast;
    logic                 w_err;
    logic [NUM_CORES-1:0] w_do_load;
    logic [NUM_CORES-1:0] w_do_start;
    logic [NUM_CORES-1:0] w_do_restart;
    logic                 w_hi_found;
    logic                 w_lo_found;
    logic [3:0]           w_hi_idx;
    logic [3:0]           w_lo_idx;
    logic                 w_gnt_valid;
    logic [3:0]           w_gnt_idx;
    logic [63:0]          w_gnt_counter;
    logic [63:0]          w_gnt_ct;
    logic                 w_unused_cmd;

    assign w_op         = cmd[3:0];
    assign w_idx        = cmd[11:8];
    assign w_bcast      = cmd[15];
    assign w_unused_cmd = ^{cmd[31:16], cmd[14:12], cmd[7:4]};

    if (N < 32) begin : g_region_unused
        logic w_unused_region;
        assign w_unused_region = ^region[31:N];
    end

    // Decode against the current core states; cores that cannot take the op flag an error.
    always_comb begin
        w_err        = !w_bcast && ({28'd0, w_idx} >= NUM_CORES);
        w_do_load    = '0;
        w_do_start   = '0;
        w_do_restart = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_bcast || (w_idx == 4'(i))) begin
                case (w_op)
                    OpLoad: begin
                        if (r_core_state[i] == CoreIdle) w_do_load[i] = 1'b1;
                        else                             w_err        = 1'b1;
                    end
                    OpStart: begin
                        if (r_core_state[i] == CoreIdle) w_do_start[i] = 1'b1;
                        else                             w_err         = 1'b1;
                    end
                    OpRestart: w_do_restart[i] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_state <= CIdle;
            r_cmd_read  <= 1'b0;
            r_cmd_error <= 1'b0;
            r_start     <= '0;
            r_restart   <= '0;
        end else begin
            r_start    <= '0;
            r_restart  <= '0;
            r_cmd_read <= 1'b0;
            case (r_cmd_state)
                CIdle: if (cmd_valid) r_cmd_state <= CExec;
                CExec: begin
                    r_start     <= w_do_start;
                    r_restart   <= w_do_restart;
                    r_cmd_state <= CAck;
                    if (w_err) r_cmd_error <= 1'b1;
                end
                CAck: begin
                    r_cmd_read <= cmd_valid;
                    if (!cmd_valid) r_cmd_state <= CIdle;
                end
                default: r_cmd_state <= CIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) r_region[i] <= '0;
        end else if (r_cmd_state == CExec) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_do_load[i]) r_region[i] <= region[N-1:0];
            end
        end
    end

    // RESTART outranks both a rising done and a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) r_core_state[i] <= CoreIdle;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (r_restart[i]) begin
                    r_core_state[i] <= CoreIdle;
                end else begin
                    case (r_core_state[i])
                        CoreIdle: if (r_start[i]) r_core_state[i] <= CoreRun;
                        CoreRun:  if (w_done[i])  r_core_state[i] <= CoreDone;
                        CoreDone: begin
                            if (w_gnt_valid && (w_gnt_idx == 4'(i))) begin
                                r_core_state[i] <= CoreReported;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // First requester above the last grant, else the lowest requester.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_core_state[i] == CoreDone) begin
                if (!w_hi_found && (i > int'(r_last))) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 4'(i);
                end
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = 4'(i);
                end
            end
        end
        w_gnt_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
        w_gnt_valid = (w_hi_found || w_lo_found) && (!r_result_valid || result_ready);
    end

    always_comb begin
        w_gnt_counter = '0;
        w_gnt_ct      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_gnt_idx == 4'(i)) begin
                w_gnt_counter = {r_region[i], w_core_cnt[i]};
                w_gnt_ct      = w_core_ct[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_valid <= 1'b0;
            r_result_core  <= '0;
            r_counter      <= '0;
            r_ciphertext   <= '0;
            r_last         <= 4'(NUM_CORES - 1);
        end else if (w_gnt_valid) begin
            r_result_valid <= 1'b1;
            r_result_core  <= w_gnt_idx;
            r_counter      <= w_gnt_counter;
            r_ciphertext   <= w_gnt_ct;
            r_last         <= w_gnt_idx;
        end else if (result_ready) begin
            r_result_valid <= 1'b0;
        end
    end

    always_comb begin
        busy           = 1'b0;
        core_done_mask = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_core_state[i] == CoreRun) busy = 1'b1;
            core_done_mask[i] = (r_core_state[i] == CoreDone) || (r_core_state[i] == CoreReported);
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        des_block #(
            .N   (N),
            .KEY (KEY)
        ) u_core (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (r_start[g]),
            .restart_block  (r_restart[g]),
            .test_enabled   (1'b0),
            .test_advance   (1'b0),
            .region         (r_region[g]),
            .counter_out    (w_core_cnt[g]),
            .ciphertext_out (w_core_ct[g]),
            .done           (w_done[g])
        );
    end

    assign cmd_read     = r_cmd_read;
    assign cmd_error    = r_cmd_error;
    assign result_valid = r_result_valid;
    assign result_core  = r_result_core;
    assign counter      = r_counter;
    assign ciphertext   = r_ciphertext;
endmodule

// File: tb/tb_des_array_controller.sv
// Directed bench for des_array_controller: command table plus hand-written result sequences.
module tb_des_array_controller;
    localparam int unsigned  NC     = 4;
    localparam int unsigned  NW     = 8;
    localparam logic [63:0]  WHITEN = 64'hDEADBEEF_0BADF00D;
    localparam logic [767:0] KEY_T  = {640'h0, WHITEN, 64'h0000_0000_0000_0123};
    localparam logic [55:0]  HIT    = 56'h123;

    logic          clk;
    logic          rst_n;
    logic [31:0]   cmd;
    logic          cmd_valid;
    logic [31:0]   region;
    logic          cmd_read;
    logic          cmd_error;
    logic          busy;
    logic [NC-1:0] core_done_mask;
    logic          result_valid;
    logic          result_ready;
    logic [3:0]    result_core;
    logic [63:0]   counter;
    logic [63:0]   ciphertext;

    int n_vec = 0;
    int n_bad = 0;
    int restart_pulses;
    logic seen_valid;

    des_array_controller #(
        .NUM_CORES (NC),
        .N         (NW),
        .KEY       (KEY_T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .region         (region),
        .cmd_read       (cmd_read),
        .cmd_error      (cmd_error),
        .busy           (busy),
        .core_done_mask (core_done_mask),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_core    (result_core),
        .counter        (counter),
        .ciphertext     (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restart_pulses <= 0;
            seen_valid     <= 1'b0;
        end else begin
            if (dut.r_restart[1]) restart_pulses <= restart_pulses + 1;
            if (result_valid) seen_valid <= 1'b1;
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [3:0]  idx;
        logic        bc;
        logic [31:0] rgn;
        logic        err;
        logic        bsy;
        logic [3:0]  mask;
    } cmd_vec_t;

    cmd_vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        cmd_valid    = 1'b0;
        result_ready = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Issues one command and checks the cmd_read handshake edge by edge.
    task automatic do_cmd(input logic [3:0] op, input logic [3:0] idx, input logic bc,
                          input logic [31:0] rgn, input string tag);
        @(posedge clk);
        #1;
        cmd       = {16'h0, bc, 3'b000, idx, 4'h0, op};
        region    = rgn;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check({tag, " cmd_read@T"}, 64'(cmd_read), 64'd0);
        @(posedge clk); #1;
        check({tag, " cmd_read@T+1"}, 64'(cmd_read), 64'd0);
        @(posedge clk); #1;
        check({tag, " cmd_read@T+2"}, 64'(cmd_read), 64'd1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, " cmd_read fall"}, 64'(cmd_read), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " result_valid timeout"}, 64'(ok), 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd          = '0;
        cmd_valid    = 1'b0;
        region       = '0;
        result_ready = 1'b0;

        //            rst   op     idx    bc    region         err   busy  mask
        vecs[0] = '{1'b1, 4'd2, 4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b0, 4'd7, 4'd0, 1'b1, 32'h0,        1'b0, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 4'd0, 4'd2, 1'b0, 32'h000000A5, 1'b0, 1'b0, 4'h0};
        vecs[3] = '{1'b0, 4'd1, 4'd5, 1'b0, 32'h0,        1'b1, 1'b0, 4'h0};
        vecs[4] = '{1'b1, 4'd1, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 4'h0};
        vecs[5] = '{1'b0, 4'd1, 4'd0, 1'b0, 32'h0,        1'b1, 1'b1, 4'h0};
        vecs[6] = '{1'b1, 4'd1, 4'd0, 1'b1, 32'h0,        1'b0, 1'b1, 4'h0};
        vecs[7] = '{1'b0, 4'd0, 4'd3, 1'b0, 32'h00000011, 1'b1, 1'b1, 4'h0};
        vecs[8] = '{1'b1, 4'd3, 4'd9, 1'b0, 32'h0,        1'b1, 1'b0, 4'h0};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) begin
                apply_reset();
                check($sformatf("vec%0d reset result_valid", i), 64'(result_valid), 64'd0);
            end
            do_cmd(vecs[i].op, vecs[i].idx, vecs[i].bc, vecs[i].rgn, $sformatf("vec%0d", i));
            check($sformatf("vec%0d cmd_error", i), 64'(cmd_error), 64'(vecs[i].err));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].bsy));
            check($sformatf("vec%0d done_mask", i), 64'(core_done_mask), 64'(vecs[i].mask));
        end

        // Region and start on core 2
        apply_reset();
        do_cmd(4'd0, 4'd2, 1'b0, 32'h000000A5, "s1 load");
        do_cmd(4'd1, 4'd2, 1'b0, 32'h0, "s1 start");
        wait_valid("s1");
        check("s1 result_core", 64'(result_core), 64'd2);
        check("s1 counter", counter, {8'hA5, HIT});
        check("s1 ciphertext", ciphertext, {8'hA5, HIT} ^ WHITEN);
        check("s1 done_mask", 64'(core_done_mask), 64'h4);
        check("s1 busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 check("s1 held", 64'(result_valid), 64'd1);
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("s1 drained", 64'(result_valid), 64'd0);
        result_ready = 1'b0;

        // Broadcast start, all cores finish together
        apply_reset();
        result_ready = 1'b1;
        do_cmd(4'd1, 4'd0, 1'b1, 32'h0, "s2 start");
        wait_valid("s2");
        check("s2 core0", 64'(result_core), 64'd0);
        check("s2 counter", counter, {8'h00, HIT});
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("s2 valid%0d", k), 64'(result_valid), 64'd1);
            check($sformatf("s2 core%0d", k), 64'(result_core), 64'(k));
        end
        @(posedge clk); #1;
        check("s2 empty", 64'(result_valid), 64'd0);
        check("s2 busy", 64'(busy), 64'd0);
        check("s2 done_mask", 64'(core_done_mask), 64'hF);
        result_ready = 1'b0;

        // Round robin with backpressure on cores 1 and 3
        apply_reset();
        do_cmd(4'd1, 4'd1, 1'b0, 32'h0, "s3 start1");
        do_cmd(4'd1, 4'd3, 1'b0, 32'h0, "s3 start3");
        wait_valid("s3");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("s3 hold core c%0d", k), {59'd0, result_valid, result_core},
                  {59'd0, 1'b1, 4'd1});
        end
        check("s3 hold counter", counter, {8'h00, HIT});
        check("s3 done_mask", 64'(core_done_mask), 64'hA);
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("s3 next valid", 64'(result_valid), 64'd1);
        check("s3 next core", 64'(result_core), 64'd3);
        @(posedge clk); #1;
        check("s3 empty", 64'(result_valid), 64'd0);
        result_ready = 1'b0;

        // RESTART core 1 while it runs
        apply_reset();
        do_cmd(4'd1, 4'd1, 1'b0, 32'h0, "s4 start");
        repeat (20) @(posedge clk);
        do_cmd(4'd3, 4'd1, 1'b0, 32'h0, "s4 restart");
        check("s4 busy", 64'(busy), 64'd0);
        check("s4 cmd_error", 64'(cmd_error), 64'd0);
        check("s4 restart pulses", 64'(restart_pulses), 64'd1);
        repeat (350) @(posedge clk);
        #1 check("s4 no result", 64'(seen_valid), 64'd0);
        check("s4 done_mask", 64'(core_done_mask), 64'h0);
        do_cmd(4'd1, 4'd1, 1'b0, 32'h0, "s4 restart-start");
        check("s4 busy again", 64'(busy), 64'd1);
        wait_valid("s4");
        check("s4 result_core", 64'(result_core), 64'd1);
        check("s4 counter", counter, {8'h00, HIT});
        check("s4 restart pulses end", 64'(restart_pulses), 64'd1);

        // Reset while a result is held, with the error flag set
        do_cmd(4'd1, 4'd7, 1'b0, 32'h0, "s5 bad");
        check("s5 cmd_error set", 64'(cmd_error), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("s5 result_valid", 64'(result_valid), 64'd0);
        check("s5 result_core", 64'(result_core), 64'd0);
        check("s5 counter", counter, 64'd0);
        check("s5 ciphertext", ciphertext, 64'd0);
        check("s5 cmd_error", 64'(cmd_error), 64'd0);
        check("s5 done_mask", 64'(core_done_mask), 64'd0);
        check("s5 cmd_read", 64'(cmd_read), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        result_ready = 1'b1;
        do_cmd(4'd1, 4'd0, 1'b1, 32'h0, "s5 start");
        wait_valid("s5");
        check("s5 first grant", 64'(result_core), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
